// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE,
    GUARD,
    SHOW
  } scan_state_t;

  localparam bcd_t BCD_MAX = 4'd9;

  function automatic logic bcd_invalid(bcd_t v);
    return v > BCD_MAX;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot timer: counts cycles within the current scan state and flags the last
// guard cycle and the last show cycle of a digit slot.
module seg7_slot_timer #(
  parameter int unsigned SLOT_CYCLES  = 50000,
  parameter int unsigned GUARD_CYCLES = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic guard_done,
  output logic slot_done
);

  localparam int unsigned CntW = $clog2(SLOT_CYCLES);
  localparam logic [CntW-1:0] GuardLast = CntW'(GUARD_CYCLES - 1);
  localparam logic [CntW-1:0] ShowLast  = CntW'(SLOT_CYCLES - GUARD_CYCLES - 1);

  logic [CntW-1:0] slot_cnt;

  // Restarts from zero on every state change; held at zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
    end else if (clear || !run) begin
      slot_cnt <= '0;
    end else begin
      slot_cnt <= slot_cnt + CntW'(1);
    end
  end

  assign guard_done = (slot_cnt == GuardLast);
  assign slot_done  = (slot_cnt == ShowLast);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller feeding one shared BCD-to-7-segment decoder,
// with frame-aligned value commit, leading-zero suppression and anti-ghost guard.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SLOT_CYCLES  = 50000,
  parameter int unsigned GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    lz_en,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    blank,
  output logic                    frame_start,
  output logic                    bcd_err
);

  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

  scan_state_t             state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_reg, disp_d;
  logic [4*NUM_DIGITS-1:0] pend_reg, pend_d;
  logic                    pend_v, pend_v_d;
  logic                    commit;
  logic                    guard_done, slot_done;
  logic                    state_change, timer_run;
  logic [NUM_DIGITS-1:0]   sup;
  logic                    zero_above;
  bcd_t                    cur_nib, next_nib;

  assign state_change = (state_d != state_q);
  assign timer_run    = (state_q != IDLE);

  seg7_slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .GUARD_CYCLES(GUARD_CYCLES)
  ) u_slot_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state_change),
    .run       (timer_run),
    .guard_done(guard_done),
    .slot_done (slot_done)
  );

  // Next state; commit marks every entry into the digit-0 guard.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    commit  = 1'b0;
    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = GUARD;
          idx_d   = '0;
          commit  = 1'b1;
        end
        GUARD: begin
          if (guard_done) state_d = SHOW;
        end
        SHOW: begin
          if (slot_done) begin
            state_d = GUARD;
            if (idx_q == IdxLast) begin
              idx_d  = '0;
              commit = 1'b1;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // New values wait in pend_reg so a frame is never torn mid-scan.
  always_comb begin
    disp_d   = disp_reg;
    pend_d   = pend_reg;
    pend_v_d = pend_v;
    if (load) begin
      pend_d   = digits_in;
      pend_v_d = 1'b1;
    end
    if (commit) begin
      if (load) begin
        disp_d = digits_in;
      end else if (pend_v) begin
        disp_d = pend_reg;
      end
      pend_v_d = 1'b0;
    end
  end

  // Scan from the MSD down, tracking whether everything at or above k is zero.
  always_comb begin
    sup        = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (disp_reg[4*k +: 4] == 4'd0);
      sup[k]     = bcd_invalid(disp_reg[4*k +: 4]) || (lz_en && zero_above && (k != 0));
    end
  end

  assign cur_nib  = disp_reg[{idx_q, 2'b00} +: 4];
  assign next_nib = disp_d[{idx_d, 2'b00} +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      disp_reg    <= '0;
      pend_reg    <= '0;
      pend_v      <= 1'b0;
      bcd_out     <= '0;
      digit_sel   <= '0;
      blank       <= 1'b1;
      frame_start <= 1'b0;
      bcd_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      disp_reg    <= disp_d;
      pend_reg    <= pend_d;
      pend_v      <= pend_v_d;
      frame_start <= commit;
      bcd_err     <= (state_q == GUARD) && (state_d == SHOW) && bcd_invalid(cur_nib);
      case (state_d)
        SHOW: begin
          bcd_out   <= next_nib;
          digit_sel <= {{(NUM_DIGITS - 1){1'b0}}, 1'b1} << idx_d;
          blank     <= sup[idx_d];
        end
        GUARD: begin
          bcd_out   <= next_nib;
          digit_sel <= '0;
          blank     <= 1'b1;
        end
        default: begin
          bcd_out   <= '0;
          digit_sel <= '0;
          blank     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: frame-position reference model plus
// directed literal scenarios and randomized load/enable/lz traffic.
module tb_seg7_scan_ctrl;

  localparam int N     = 4;
  localparam int SLOT  = 8;
  localparam int GUARD = 2;
  localparam int FRAME = N * SLOT;

  typedef struct packed {
    logic [3:0] bcd;
    logic [3:0] sel;
    logic       blank;
    logic       fs;
    logic       err;
  } out_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         load;
  logic [15:0]  digits_in;
  logic         lz_en;
  logic [3:0]   bcd_out;
  logic [3:0]   digit_sel;
  logic         blank;
  logic         frame_start;
  logic         bcd_err;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (N),
    .SLOT_CYCLES (SLOT),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .digits_in  (digits_in),
    .lz_en      (lz_en),
    .bcd_out    (bcd_out),
    .digit_sel  (digit_sel),
    .blank      (blank),
    .frame_start(frame_start),
    .bcd_err    (bcd_err)
  );

  // Reference model: position in the scan is just elapsed enabled cycles.
  int          m_s    = -1;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  bit          m_pv   = 1'b0;
  out_t        e_out  = '{bcd: 4'd0, sel: 4'd0, blank: 1'b1, fs: 1'b0, err: 1'b0};

  function automatic out_t model_out(int s, logic [15:0] disp, logic lz);
    out_t o;
    int p, d, w;
    logic [3:0] nib;
    logic [15:0] upper;
    o = '{bcd: 4'd0, sel: 4'd0, blank: 1'b1, fs: 1'b0, err: 1'b0};
    if (s < 0) return o;
    p     = s % FRAME;
    d     = p / SLOT;
    w     = p % SLOT;
    upper = disp >> (4 * d);
    nib   = upper[3:0];
    o.bcd = nib;
    o.fs  = (p == 0);
    if (w >= GUARD) begin
      o.sel   = 4'(1 << d);
      o.blank = (nib > 4'd9) || (lz && d > 0 && upper == 16'd0);
      o.err   = (w == GUARD) && (nib > 4'd9);
    end
    return o;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int          s_n;
    logic [15:0] disp_n, pend_n;
    bit          pv_n;
    if (!rst_n) begin
      m_s    <= -1;
      m_disp <= '0;
      m_pend <= '0;
      m_pv   <= 1'b0;
      e_out  <= model_out(-1, 16'd0, 1'b0);
    end else begin
      s_n    = en ? m_s + 1 : -1;
      disp_n = m_disp;
      pend_n = m_pend;
      pv_n   = m_pv;
      if (en && (s_n % FRAME == 0)) begin
        if (load) disp_n = digits_in;
        else if (m_pv) disp_n = m_pend;
        pv_n = 1'b0;
        if (load) pend_n = digits_in;
      end else if (load) begin
        pend_n = digits_in;
        pv_n   = 1'b1;
      end
      m_s    <= s_n;
      m_disp <= disp_n;
      m_pend <= pend_n;
      m_pv   <= pv_n;
      e_out  <= model_out(s_n, disp_n, lz_en);
    end
  end

  always @(negedge clk) begin
    out_t act;
    if (started) begin
      act = '{bcd: bcd_out, sel: digit_sel, blank: blank, fs: frame_start, err: bcd_err};
      total++;
      if (act !== e_out) begin
        bad++;
        $display("FAIL cycle_model t=%0t got bcd=%h sel=%b blank=%b fs=%b err=%b want bcd=%h sel=%b blank=%b fs=%b err=%b",
                 $time, act.bcd, act.sel, act.blank, act.fs, act.err,
                 e_out.bcd, e_out.sel, e_out.blank, e_out.fs, e_out.err);
      end
      total++;
      if (!$onehot0(digit_sel)) begin
        bad++;
        $display("FAIL onehot0 t=%0t got sel=%b want at most one bit", $time, digit_sel);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for frame_start, records the first SHOW cycle of each slot.
  task automatic capture_frame(output logic [15:0] nibs, output logic [15:0] sels,
                               output logic [3:0] blanks, output int errs);
    int n;
    nibs   = '0;
    sels   = '0;
    blanks = '0;
    errs   = 0;
    n      = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 200);
    chk("frame_start_seen", 32'(frame_start), 32'd1);
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) @(negedge clk);
      if (bcd_err) errs++;
      if (c % SLOT == GUARD) begin
        nibs[4*(c/SLOT) +: 4] = bcd_out;
        sels[4*(c/SLOT) +: 4] = digit_sel;
        blanks[c/SLOT]        = blank;
      end
    end
    @(negedge clk);
    chk("frame_period_32", 32'(frame_start), 32'd1);
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    for (int k = 0; k < N; k++) begin
      if ($urandom_range(0, 15) == 0) v[4*k +: 4] = 4'($urandom_range(10, 15));
      else v[4*k +: 4] = 4'($urandom_range(0, 9));
    end
    if ($urandom_range(0, 3) == 0) v = v >> (4 * $urandom_range(1, 3));
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got no finish want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] nibs, sels;
    logic [3:0]  blanks;
    int          errs, off_cnt;

    rst_n     = 1'b0;
    en        = 1'b0;
    load      = 1'b0;
    digits_in = '0;
    lz_en     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_bcd", 32'(bcd_out), 32'd0);
    chk("reset_sel", 32'(digit_sel), 32'd0);
    chk("reset_blank", 32'(blank), 32'd1);
    chk("reset_fs_err", 32'({frame_start, bcd_err}), 32'd0);
    rst_n   = 1'b1;
    started = 1'b1;

    // 1: load 1234 together with enable
    tick();
    en        = 1'b1;
    load      = 1'b1;
    digits_in = 16'h1234;
    tick();
    load = 1'b0;
    @(negedge clk);
    chk("model_pin_fs", 32'(e_out.fs), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("model_pin_sel0", 32'(e_out.sel), 32'h1);
    chk("model_pin_bcd0", 32'(e_out.bcd), 32'h4);
    capture_frame(nibs, sels, blanks, errs);
    chk("t1_nibs", 32'(nibs), 32'h1234);
    chk("t1_sels", 32'(sels), 32'h8421);
    chk("t1_blanks", 32'(blanks), 32'h0);

    // 2: mid-frame loads must not tear; last load wins
    repeat (18) @(posedge clk);
    #1;
    load      = 1'b1;
    digits_in = 16'h5678;
    tick();
    load = 1'b0;
    @(negedge clk);
    chk("t2_slot2_bcd", 32'(bcd_out), 32'h2);
    chk("t2_slot2_sel", 32'(digit_sel), 32'h4);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("t2_slot3_bcd", 32'(bcd_out), 32'h1);
    chk("t2_slot3_sel", 32'(digit_sel), 32'h8);
    tick();
    load      = 1'b1;
    digits_in = 16'h9999;
    tick();
    load = 1'b0;
    capture_frame(nibs, sels, blanks, errs);
    chk("t2_last_wins", 32'(nibs), 32'h9999);

    // 3: leading-zero suppression
    tick();
    lz_en     = 1'b1;
    load      = 1'b1;
    digits_in = 16'h0050;
    tick();
    load = 1'b0;
    capture_frame(nibs, sels, blanks, errs);
    chk("t3_0050_blanks", 32'(blanks), 32'hC);
    chk("t3_0050_d1d0", 32'(nibs[7:0]), 32'h50);
    tick();
    load      = 1'b1;
    digits_in = 16'h0000;
    tick();
    load = 1'b0;
    capture_frame(nibs, sels, blanks, errs);
    chk("t3_0000_blanks", 32'(blanks), 32'hE);
    chk("t3_0000_d0", 32'(nibs[3:0]), 32'h0);

    // 4: invalid nibble blanks its slot and pulses bcd_err once
    tick();
    lz_en     = 1'b0;
    load      = 1'b1;
    digits_in = 16'h00A3;
    tick();
    load = 1'b0;
    capture_frame(nibs, sels, blanks, errs);
    chk("t4_nibs", 32'(nibs), 32'h00A3);
    chk("t4_blanks", 32'(blanks), 32'h2);
    chk("t4_err_pulses", 32'(errs), 32'd1);

    // 5: drop en during digit 2 show, then restart
    repeat (18) @(posedge clk);
    #1;
    en = 1'b0;
    @(negedge clk);
    chk("t5_still_d2", 32'(digit_sel), 32'h4);
    @(negedge clk);
    chk("t5_dark_sel", 32'(digit_sel), 32'h0);
    chk("t5_dark_blank", 32'(blank), 32'd1);
    @(posedge clk);
    #1;
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_restart_fs", 32'(frame_start), 32'd1);
    chk("t5_restart_guard_sel", 32'(digit_sel), 32'h0);
    repeat (2) @(negedge clk);
    chk("t5_restart_sel", 32'(digit_sel), 32'h1);
    chk("t5_restart_bcd", 32'(bcd_out), 32'h3);

    // 6: async reset mid-SHOW, off the clock edge
    repeat (8) @(negedge clk);
    chk("t6_pre_sel", 32'(digit_sel), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_sel", 32'(digit_sel), 32'h0);
    chk("t6_async_blank", 32'(blank), 32'd1);
    chk("t6_async_bcd", 32'(bcd_out), 32'h0);
    chk("t6_async_fs_err", 32'({frame_start, bcd_err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic checked against the model every cycle
    off_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      digits_in = rand_digits();
      load      = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) lz_en = ~lz_en;
      if (en && $urandom_range(0, 299) == 0) begin
        en      = 1'b0;
        off_cnt = $urandom_range(1, 6);
      end else if (!en) begin
        off_cnt--;
        if (off_cnt <= 0) en = 1'b1;
      end
    end
    tick();
    load = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
